// File: rtl/decode_stage.sv
// decode_stage: pipelined RISC-V (RV32I subset) decode stage.
//
// Decodes R-type, I-ALU, lw, sw, beq/bne and jal; anything else is a NOP.
// Holds the 32x32 register file (two combinational read ports with
// write-through bypass from writeback, x0 hard-wired to zero), resolves
// branches/jumps in this stage (PCSrcD/PCBranchD), and registers all
// execute-stage values in the D/E pipeline register.
//
// Configuration macro: BRANCH_FWD_EN
//   defined   -> branch compare operands may be forwarded from ALUOutM
//                (ForwardAD / ForwardBD select).
//   undefined -> compares use register-file data only; the forwarding
//                ports remain but are ignored.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   InstrD, PCPlus4D      instruction and PC+4 from the fetch register
//   RegWriteW, RdW,
//   ResultW               register-file write port (writeback)
//   FlushE, StallE        D/E register controls (flush wins over stall)
//   ForwardAD, ForwardBD,
//   ALUOutM               branch-compare forwarding select and data
//   PCSrcD, PCBranchD     taken branch/jump and its target
//   Rs1D, Rs2D            source indices to the hazard unit
//   *E outputs            D/E register contents
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  input  logic        StallE,
  input  logic        ForwardAD,
  input  logic        ForwardBD,
  input  logic [31:0] ALUOutM,
  output logic        PCSrcD,
  output logic [31:0] PCBranchD,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic        RegWriteE,
  output logic        MemtoRegE,
  output logic        MemWriteE,
  output logic        ALUSrcE,
  output logic        JumpE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE
);

  typedef enum logic [6:0] {
    OP_R   = 7'b0110011,
    OP_I   = 7'b0010011,
    OP_LW  = 7'b0000011,
    OP_SW  = 7'b0100011,
    OP_BR  = 7'b1100011,
    OP_JAL = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_sel_e;

  typedef struct packed {
    logic        reg_write;
    logic        memto_reg;
    logic        mem_write;
    logic        alu_src;
    logic        jump;
    logic [2:0]  alu_ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc_plus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } de_t;

  logic [2:0]  funct3;
  logic        funct7_b5;
  alu_op_e     alu_f3;
  logic        f3_ok;
  alu_op_e     alu_op;
  imm_sel_e    imm_sel;
  logic        reg_write, memto_reg, mem_write, alu_src, jump;
  logic        rd_used, is_beq, is_bne, is_jal;
  logic [31:0] imm_ext;
  logic [31:0] rd1, rd2;
  logic [31:0] cmp_a, cmp_b;
  logic [31:0] regs_q [32];
  de_t         de_d, de_q;

  assign funct3    = InstrD[14:12];
  assign funct7_b5 = InstrD[30];
  assign Rs1D      = InstrD[19:15];
  assign Rs2D      = InstrD[24:20];

  // funct3 -> ALU op shared by R-type and I-ALU; unsupported funct3 flagged.
  always_comb begin
    alu_f3 = ALU_ADD;
    f3_ok  = 1'b1;
    case (funct3)
      3'b000:  alu_f3 = ALU_ADD;
      3'b111:  alu_f3 = ALU_AND;
      3'b110:  alu_f3 = ALU_OR;
      3'b100:  alu_f3 = ALU_XOR;
      3'b010:  alu_f3 = ALU_SLT;
      3'b001:  alu_f3 = ALU_SLL;
      3'b101:  alu_f3 = ALU_SRL;
      default: f3_ok  = 1'b0;
    endcase
  end

  always_comb begin
    reg_write = 1'b0;
    memto_reg = 1'b0;
    mem_write = 1'b0;
    alu_src   = 1'b0;
    jump      = 1'b0;
    alu_op    = ALU_ADD;
    imm_sel   = IMM_NONE;
    rd_used   = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_jal    = 1'b0;
    case (InstrD[6:0])
      OP_R: if (f3_ok) begin
        reg_write = 1'b1;
        alu_op    = (funct3 == 3'b000 && funct7_b5) ? ALU_SUB : alu_f3;
        rd_used   = 1'b1;
      end
      OP_I: if (f3_ok) begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = alu_f3;
        imm_sel   = IMM_I;
        rd_used   = 1'b1;
      end
      OP_LW: if (funct3 == 3'b010) begin
        reg_write = 1'b1;
        memto_reg = 1'b1;
        alu_src   = 1'b1;
        imm_sel   = IMM_I;
        rd_used   = 1'b1;
      end
      OP_SW: if (funct3 == 3'b010) begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm_sel   = IMM_S;
      end
      OP_BR: begin
        if (funct3 == 3'b000) begin
          is_beq  = 1'b1;
          imm_sel = IMM_B;
        end else if (funct3 == 3'b001) begin
          is_bne  = 1'b1;
          imm_sel = IMM_B;
        end
      end
      OP_JAL: begin
        reg_write = 1'b1;
        jump      = 1'b1;
        is_jal    = 1'b1;
        imm_sel   = IMM_J;
        rd_used   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    imm_ext = '0;
    case (imm_sel)
      IMM_I:   imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S:   imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25],
                          InstrD[11:8], 1'b0};
      IMM_J:   imm_ext = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20],
                          InstrD[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  // Read ports: x0 reads zero; a same-cycle write to the read index is
  // passed straight through so writeback and decode can share a cycle.
  always_comb begin
    rd1 = '0;
    if (Rs1D == '0)                                  rd1 = '0;
    else if (RegWriteW && RdW != '0 && RdW == Rs1D)  rd1 = ResultW;
    else                                             rd1 = regs_q[Rs1D];
  end

  always_comb begin
    rd2 = '0;
    if (Rs2D == '0)                                  rd2 = '0;
    else if (RegWriteW && RdW != '0 && RdW == Rs2D)  rd2 = ResultW;
    else                                             rd2 = regs_q[Rs2D];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i[4:0]] <= '0;
    end else if (RegWriteW && RdW != '0) begin
      regs_q[RdW] <= ResultW;
    end
  end

`ifdef BRANCH_FWD_EN
  assign cmp_a = ForwardAD ? ALUOutM : rd1;
  assign cmp_b = ForwardBD ? ALUOutM : rd2;
`else
  logic unused_fwd;
  assign unused_fwd = ^{ForwardAD, ForwardBD, ALUOutM};
  assign cmp_a = rd1;
  assign cmp_b = rd2;
`endif

  assign PCSrcD    = (is_beq && (cmp_a == cmp_b)) ||
                     (is_bne && (cmp_a != cmp_b)) || is_jal;
  assign PCBranchD = (PCPlus4D - 32'd4) + imm_ext;

  always_comb begin
    de_d           = '0;
    de_d.reg_write = reg_write;
    de_d.memto_reg = memto_reg;
    de_d.mem_write = mem_write;
    de_d.alu_src   = alu_src;
    de_d.jump      = jump;
    de_d.alu_ctrl  = alu_op;
    de_d.rd1       = rd1;
    de_d.rd2       = rd2;
    de_d.imm       = imm_ext;
    de_d.pc_plus4  = PCPlus4D;
    de_d.rs1       = Rs1D;
    de_d.rs2       = Rs2D;
    de_d.rd        = rd_used ? InstrD[11:7] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset || FlushE) de_q <= '0;
    else if (!StallE)    de_q <= de_d;
  end

  assign RegWriteE   = de_q.reg_write;
  assign MemtoRegE   = de_q.memto_reg;
  assign MemWriteE   = de_q.mem_write;
  assign ALUSrcE     = de_q.alu_src;
  assign JumpE       = de_q.jump;
  assign ALUControlE = de_q.alu_ctrl;
  assign RD1E        = de_q.rd1;
  assign RD2E        = de_q.rd2;
  assign ImmExtE     = de_q.imm;
  assign PCPlus4E    = de_q.pc_plus4;
  assign Rs1E        = de_q.rs1;
  assign Rs2E        = de_q.rs2;
  assign RdE         = de_q.rd;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL have ports InstrD (input, 32) and PCPlus4D (input, 32), the instruction and PC+4 from the fetch pipeline register.
REQ-004 SHALL have ports RegWriteW (input, 1), RdW (input, 5) and ResultW (input, 32), forming the writeback register-file write port.
REQ-005 SHALL have ports FlushE (input, 1) and StallE (input, 1), execute-register controls from the hazard unit.
REQ-006 SHALL have ports ForwardAD (input, 1), ForwardBD (input, 1) and ALUOutM (input, 32), the branch-compare forwarding controls and data.
REQ-007 SHALL have ports PCSrcD (output, 1), taken branch/jump, and PCBranchD (output, 32), the target to fetch.
REQ-008 SHALL have ports Rs1D (output, 5) and Rs2D (output, 5), source indices to the hazard unit.
REQ-009 SHALL have 1-bit outputs RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, JumpE, and a 3-bit output ALUControlE.
REQ-010 SHALL have ports RD1E (output, 32), RD2E (output, 32), ImmExtE (output, 32), PCPlus4E (output, 32), Rs1E (output, 5), Rs2E (output, 5) and RdE (output, 5).

Function
REQ-011 SHALL decode opcodes R-type 0110011, I-ALU 0010011, lw 0000011, sw 0100011, branch 1100011 (beq/bne) and jal 1101111.
REQ-012 Any other opcode or funct3 SHALL decode as NOP: all control bits 0, PCSrcD 0.
REQ-013 ALUControl encoding SHALL be: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
REQ-014 ALUControl SHALL select sub only for R-type with funct7[5]=1 and funct3=000; lw and sw SHALL use add.
REQ-015 Immediates SHALL be sign-extended from InstrD[31]: I, S, B (bit0=0) and J (bit0=0) formats per RV32I.
REQ-016 The register file SHALL hold 32x32 bits with 2 combinational read ports (Rs1D=InstrD[19:15], Rs2D=InstrD[24:20]).
REQ-017 The register file SHALL have 1 write port written on the rising clk when RegWriteW=1 and RdW!=0.
REQ-018 x0 SHALL always read 0; writes to x0 SHALL be ignored.
REQ-019 A read whose index equals RdW while RegWriteW=1 and RdW!=0 SHALL return ResultW in the same cycle (write-through bypass).
REQ-020 Compare operands SHALL be ALUOutM when ForwardAD/ForwardBD=1, otherwise the register-file read data.
REQ-021 PCSrcD SHALL be (beq & A==B) | (bne & A!=B) | jal, and SHALL be combinational with zero latency.
REQ-022 PCBranchD SHALL be (PCPlus4D - 4) + ImmExt, computed modulo 2^32 (wrap-around permitted).
REQ-023 The D/E register SHALL capture all E outputs each rising clk, with 1-cycle latency.
REQ-024 With StallE=1 the D/E register SHALL hold its contents.
REQ-025 With FlushE=1 the D/E register SHALL load all zeros; FlushE SHALL take priority over StallE.
REQ-026 RdE SHALL be InstrD[11:7] for R, I-ALU, lw and jal, and 0 for sw, branch and NOP.

Reset
REQ-027 On reset=1 all D/E register outputs SHALL be 0 on the next rising clk.
REQ-028 On reset=1 all 32 registers SHALL be 0 on the next rising clk.
REQ-029 Reset SHALL override FlushE, StallE and any register-file write in the same cycle.
REQ-030 Reset asserted mid-operation SHALL discard in-flight decode state; the first instruction after deassertion SHALL decode normally.

Configuration
REQ-031 The macro BRANCH_FWD_EN SHALL control branch-compare forwarding.
REQ-032 With BRANCH_FWD_EN defined, REQ-020 forwarding SHALL apply.
REQ-033 Without BRANCH_FWD_EN, ForwardAD, ForwardBD and ALUOutM SHALL be ignored and compares SHALL use register-file data only; the ports SHALL remain present.

Verification
REQ-034 Write x5=0x12345678 (RegWriteW=1, RdW=5) while decoding add x1,x5,x0 in the same cycle -> RD1E=0x12345678 next cycle (bypass).
REQ-035 beq x1,x2,+16 at PC 0x100 with x1=x2=7 -> PCSrcD=1, PCBranchD=0x110; with x2=8 -> PCSrcD=0.
REQ-036 jal x1,-8 at PC 0x0 -> PCSrcD=1, PCBranchD=0xFFFFFFF8, JumpE=1, RdE=1.
REQ-037 FlushE=1 together with StallE=1 while decoding sw -> all E outputs 0 next cycle.
REQ-038 Write x0=0xFFFFFFFF, then read x0 -> 0.
REQ-039 Reset mid-stream after x3 is written -> x3 reads 0.
REQ-040 With BRANCH_FWD_EN: ForwardAD=1, ALUOutM=9, x2=9, beq x1,x2 -> PCSrcD=1; without BRANCH_FWD_EN, same stimulus with x1=0 -> PCSrcD=0.
